// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised serial input, mid-bit sampling, LSB first,
// one stop bit; emits one-cycle dataValid / frameError pulses.
module uart_rx #(
  parameter int ClockFrequency = 50000000,
  parameter int BaudRate       = 115200,
  parameter int NrOfDataBits   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rx,
  output logic [NrOfDataBits-1:0] dataBits,
  output logic                    dataValid,
  output logic                    frameError,
  output logic                    busy
);

  localparam int ClocksPerBit = ClockFrequency / BaudRate;
  localparam int HalfBit      = ClocksPerBit / 2;
  localparam int TW           = $clog2(ClocksPerBit);
  localparam int IW           = (NrOfDataBits > 1) ? $clog2(NrOfDataBits) : 1;

  localparam logic [TW-1:0] HalfLast = TW'(HalfBit - 1);
  localparam logic [TW-1:0] BitLast  = TW'(ClocksPerBit - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(NrOfDataBits - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                  state, state_n;
  logic                    sync1, rxs;
  logic [TW-1:0]           timer, timer_n;
  logic [IW-1:0]           idx, idx_n;
  logic [NrOfDataBits-1:0] shift, shift_n;
  logic [NrOfDataBits-1:0] data_n;
  logic                    valid_n, ferr_n;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1      <= 1'b1;
      rxs        <= 1'b1;
      state      <= S_IDLE;
      timer      <= '0;
      idx        <= '0;
      shift      <= '0;
      dataBits   <= '0;
      dataValid  <= 1'b0;
      frameError <= 1'b0;
    end else begin
      sync1      <= rx;
      rxs        <= sync1;
      state      <= state_n;
      timer      <= timer_n;
      idx        <= idx_n;
      shift      <= shift_n;
      dataBits   <= data_n;
      dataValid  <= valid_n;
      frameError <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = (timer == BitLast) ? '0 : timer + TW'(1);
    idx_n   = idx;
    shift_n = shift;
    data_n  = dataBits;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxs) state_n = S_START;
      end
      S_START: begin
        if (timer == HalfLast) begin
          idx_n   = '0;
          state_n = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (timer == BitLast) begin
          // Shift right with the new bit at the MSB so bit 0 ends up holding the first bit.
          shift_n = shift >> 1;
          shift_n[NrOfDataBits-1] = rxs;
          idx_n = idx + IW'(1);
          if (idx == IdxLast) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (timer == BitLast) begin
          if (rxs) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (state_n != state) timer_n = '0;
  end

  always_comb busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialised by a behavioural transmitter,
// expected words and arrival cycles are queued, and a monitor checks every pulse.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int Cpb = 16;
  localparam int Latency = 2 + Cpb / 2 + 9 * Cpb;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dataBits;
  logic       dataValid, frameError, busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          cyc = 0;

  typedef struct {
    bit         fe;
    logic [7:0] val;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  logic [7:0] model_last = 8'h00;
  int         vals[256];

  uart_rx #(
    .ClockFrequency(16),
    .BaudRate      (1),
    .NrOfDataBits  (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .dataBits  (dataBits),
    .dataValid (dataValid),
    .frameError(frameError),
    .busy      (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Caller must be at a negedge; returns at a negedge with rx holding the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_t x;
    x.fe  = !stop;
    x.val = d;
    x.cyc = cyc + 1 + Latency;
    q.push_back(x);
    rx = 1'b0;
    repeat (Cpb) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (Cpb) @(negedge clock);
    end
    rx = stop;
    repeat (Cpb) @(negedge clock);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (reset && (dataValid || frameError)) begin
      check("exclusive_pulse", {31'd0, dataValid && frameError}, 32'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse dv=%0b fe=%0b data=%0h required=no_pulse (cycle %0d)",
                 dataValid, frameError, dataBits, cyc);
      end else begin
        e = q.pop_front();
        check("pulse_kind_fe", {31'd0, frameError}, {31'd0, e.fe});
        check("latency", cyc, e.cyc);
        if (!e.fe) begin
          check("data", {24'd0, dataBits}, {24'd0, e.val});
          model_last = e.val;
        end else begin
          check("data_kept_on_ferr", {24'd0, dataBits}, {24'd0, model_last});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish (queue=%0d)", q.size());
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Test 1: reset
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_data", {24'd0, dataBits}, 32'd0);
    check("rst_valid", {31'd0, dataValid}, 32'd0);
    check("rst_ferr", {31'd0, frameError}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    idle(5);

    // Test 2: single frame with exact latency
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("idle_after_a5", {31'd0, busy}, 32'd0);

    // Test 3: short glitch rejected
    rx = 1'b0;
    repeat (5) @(negedge clock);
    idle(40);
    check("glitch_busy", {31'd0, busy}, 32'd0);

    // Test 4: stop bit low, then recovery
    send_frame(8'h3C, 1'b0);
    idle(40);
    check("break_exit_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h81, 1'b1);
    idle(20);

    // Test 5: back to back
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    idle(20);

    // Test 6: reset in the middle of a frame
    rx = 1'b0;
    repeat (Cpb) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 1) ? 1'b1 : 1'b1 & ~i[0];
      repeat (Cpb) @(negedge clock);
    end
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clock);
    model_last = 8'h00;
    check("midrst_data", {24'd0, dataBits}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    idle(10 * Cpb);
    send_frame(8'h12, 1'b1);
    idle(20);

    // Test 7: all 256 values in shuffled order with random gaps (some back to back)
    for (int i = 0; i < 256; i++) vals[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i, 0);
      t = vals[i];
      vals[i] = vals[j];
      vals[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      send_frame(8'(vals[i]), 1'b1);
      if ($urandom_range(3, 0) != 0) idle($urandom_range(20, 1));
    end

    for (int i = 0; i < 400 && q.size() > 0; i++) @(negedge clock);
    check("queue_drained", q.size(), 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
